ltl_report_collector: RTL and testbench
=======================================

Name: ltl_report_collector

Overview:
- Sits directly downstream of a cluster's LTL automaton and consumes its report-node active-state wires once per consumed symbol.
- Detects newly asserted reports and tags them with the symbol index and cluster ID.
- Buffers the tagged records in a small FIFO and presents them to the monitor aggregation/CSR logic over a valid/ready interface.
- Also keeps per-report sticky status bits and a saturating count of dropped records.

Parameters:
NUM_REPORTS, 4, number of report wires from the automaton (1..16)
TS_WIDTH, 32, symbol-index timestamp width
FIFO_DEPTH, 8, record buffer depth (power of two, >=2)
ID_WIDTH, 4, cluster ID width
CLUSTER_ID, 7, constant ID stamped into every record
DROP_WIDTH, 16, dropped-record counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
report_strobe  in  1  one-cycle pulse: report_in reflects a newly consumed symbol
report_in  in  NUM_REPORTS  automaton report active states
clear_sticky  in  1  clears sticky_status
rec_valid  out  1  record available at FIFO head
rec_ready  in  1  consumer accepts the head record
rec_report  out  NUM_REPORTS  rising-edge report vector of the head record
rec_timestamp  out  TS_WIDTH  symbol index of the head record
rec_cluster_id  out  ID_WIDTH  equals CLUSTER_ID
rec_overflow  out  1  one or more records were dropped before this record
sticky_status  out  NUM_REPORTS  OR of all recorded rising edges since the last clear
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
dropped_count  out  DROP_WIDTH  saturating count of dropped records

Behaviour:
- Reset: all outputs 0, FIFO empty, prev_report=0, sym_cnt=0, pending_ovf=0.
- Sampling happens only in cycles where report_strobe=1. report_in is ignored otherwise, and prev_report holds.
- On a strobe:
  - rise = report_in & ~prev_report.
  - prev_report <= report_in.
  - sym_cnt <= sym_cnt+1, wrapping modulo 2^TS_WIDTH.
  - The record timestamp is the pre-increment sym_cnt, so the first strobe after reset has timestamp 0.
- The first strobe after reset with report_in!=0 counts as a rising edge.
- An event occurs when strobe=1 and rise!=0. A level held over consecutive strobes produces no further events until it drops and rises again.
- Event with FIFO not full: push {pending_ovf, CLUSTER_ID, timestamp, rise}, then pending_ovf <= 0.
- Event with FIFO full: drop the record, dropped_count <= dropped_count+1 (saturating at all-ones), pending_ovf <= 1.
- A full FIFO drops the event even if rec_ready pops in the same cycle. The push decision uses pre-pop occupancy.
- Pop happens when rec_valid && rec_ready. Outputs are first-word-fall-through: rec_* shows the head combinationally from storage.
  - rec_* is stable while rec_valid=1 and rec_ready=0.
  - rec_* is don't-care when rec_valid=0; the bench checks it only under valid.
- Push to an empty FIFO: rec_valid rises the cycle after the push edge, so latency is 1 cycle from strobe to rec_valid.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_count unchanged.
- fifo_count and rec_valid are registered-state-derived, with rec_valid = (fifo_count!=0).
- Read/write pointers wrap modulo FIFO_DEPTH. Full means count==FIFO_DEPTH.
- sticky_status <= (clear_sticky ? 0 : sticky_status) | (event ? rise : 0).
  - Set wins over clear in the same cycle.
  - Dropped events still set sticky bits.
- dropped_count is cleared only by reset.
- Reset mid-operation: contents are discarded immediately, including any record in flight on rec_*, and rec_valid=0 the cycle after reset is sampled.
- No combinational path from rec_ready to rec_valid.

Test Plan:
- Reset, then strobes with report_in = 0000, 0010, 0010, 0000, 0010 -> two records: (rise 0010, ts 1) and (rise 0010, ts 4), cluster_id 7, overflow 0.
- Strobe with report_in=1001 and rec_ready=1 -> rec_valid=1 the next cycle with rec_report=1001; popped that cycle; fifo_count returns to 0; sticky_status=1001.
- rec_ready=0, then 10 distinct rising events (FIFO_DEPTH=8) -> fifo_count=8 and dropped_count=2. Drain 8 records with ts in order, each overflow=0. The next event record has overflow=1, and the one after has overflow=0.
- FIFO full, an event and a pop in the same cycle -> event dropped (dropped_count+1), fifo_count=7.
- clear_sticky=1 in the same cycle as an event with rise=0100 -> sticky_status=0100. A later clear_sticky alone -> 0000.
- report_in toggling with report_strobe=0 -> no records and sym_cnt unchanged. A reset asserted with 3 records queued -> rec_valid=0, fifo_count=0, and the next event has ts 0.

Source files
------------

// File: rtl/ltl_report_collector.sv
// rtl/ltl_report_collector.sv - tags LTL report rising edges and queues them for the monitor
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int TS_WIDTH    = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int ID_WIDTH    = 4,
  parameter int CLUSTER_ID  = 7,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          report_strobe,
  input  logic [NUM_REPORTS-1:0]        report_in,
  input  logic                          clear_sticky,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [NUM_REPORTS-1:0]        rec_report,
  output logic [TS_WIDTH-1:0]           rec_timestamp,
  output logic [ID_WIDTH-1:0]           rec_cluster_id,
  output logic                          rec_overflow,
  output logic [NUM_REPORTS-1:0]        sticky_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_WIDTH-1:0]         dropped_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 1 + ID_WIDTH + TS_WIDTH + NUM_REPORTS;
  localparam logic [ID_WIDTH-1:0] CID   = ID_WIDTH'(CLUSTER_ID);
  localparam logic [CNT_W-1:0]    FULLC = CNT_W'(FIFO_DEPTH);

  logic [REC_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [NUM_REPORTS-1:0] prev_report;
  logic [NUM_REPORTS-1:0] rise;
  logic [TS_WIDTH-1:0]    sym_cnt;
  logic                   pending_ovf;
  logic                   evt;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [REC_W-1:0]       head;

  // Push decision uses pre-pop occupancy, so a full FIFO drops even when popping.
  always_comb begin
    rise = report_in & ~prev_report;
    evt  = report_strobe && (rise != '0);
    full = (fifo_count == FULLC);
    push = evt && !full;
    pop  = rec_valid && rec_ready;
  end

  assign rec_valid = (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_report   <= '0;
      sym_cnt       <= '0;
      pending_ovf   <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      sticky_status <= '0;
      dropped_count <= '0;
    end else begin
      if (report_strobe) begin
        prev_report <= report_in;
        sym_cnt     <= sym_cnt + TS_WIDTH'(1);
      end
      if (push) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        pending_ovf <= 1'b0;
      end else if (evt) begin
        pending_ovf <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (evt && full && (dropped_count != '1)) begin
        dropped_count <= dropped_count + DROP_WIDTH'(1);
      end
      // Dropped events still mark sticky bits; a set beats a same-cycle clear.
      sticky_status <= (clear_sticky ? '0 : sticky_status) | (evt ? rise : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {pending_ovf, CID, sym_cnt, rise};
    end
  end

  assign head = mem[rd_ptr];

  // Head fields are forced to zero when empty so outputs read 0 out of reset.
  assign rec_report     = rec_valid ? head[NUM_REPORTS-1:0] : '0;
  assign rec_timestamp  = rec_valid ? head[NUM_REPORTS +: TS_WIDTH] : '0;
  assign rec_cluster_id = rec_valid ? head[NUM_REPORTS+TS_WIDTH +: ID_WIDTH] : '0;
  assign rec_overflow   = rec_valid ? head[REC_W-1] : 1'b0;

endmodule

// File: tb/tb_ltl_report_collector.sv
// tb/tb_ltl_report_collector.sv - scoreboard bench for ltl_report_collector
module tb_ltl_report_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        report_strobe = 1'b0;
  logic [3:0]  report_in = '0;
  logic        clear_sticky = 1'b0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [3:0]  rec_report;
  logic [31:0] rec_timestamp;
  logic [3:0]  rec_cluster_id;
  logic        rec_overflow;
  logic [3:0]  sticky_status;
  logic [3:0]  fifo_count;
  logic [15:0] dropped_count;

  ltl_report_collector dut (
    .clk(clk), .reset(reset), .report_strobe(report_strobe), .report_in(report_in),
    .clear_sticky(clear_sticky), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_report(rec_report), .rec_timestamp(rec_timestamp), .rec_cluster_id(rec_cluster_id),
    .rec_overflow(rec_overflow), .sticky_status(sticky_status), .fifo_count(fifo_count),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rep;
    logic [31:0] ts;
    logic [3:0]  id;
    logic        ovf;
  } rec_t;

  rec_t        sb[$];
  logic [3:0]  m_prev;
  logic [31:0] m_sym;
  logic        m_pend;
  logic [15:0] m_drop;
  logic [3:0]  m_sticky;
  int          checks = 0;
  int          passed = 0;

  task automatic model_reset();
    sb.delete();
    m_prev = '0; m_sym = '0; m_pend = 1'b0; m_drop = '0; m_sticky = '0;
  endtask

  // Drives one clock of stimulus; returns the head seen before the edge and the model's expectation.
  task automatic cycle(input logic s, input logic [3:0] r, input logic clr, input logic rdy,
                       output logic popped, output rec_t obs, output rec_t exp);
    logic [3:0] rise;
    logic       was_full;
    rec_t       nr;
    report_strobe = s; report_in = r; clear_sticky = clr; rec_ready = rdy;
    #1;
    popped  = rec_valid && rdy;
    obs.rep = rec_report; obs.ts = rec_timestamp; obs.id = rec_cluster_id; obs.ovf = rec_overflow;
    exp = '0;
    rise = s ? (r & ~m_prev) : 4'b0000;
    was_full = (sb.size() == 8);
    if (rdy && sb.size() != 0) exp = sb.pop_front();
    if (rise != 4'b0000) begin
      if (!was_full) begin
        nr.rep = rise; nr.ts = m_sym; nr.id = 4'd7; nr.ovf = m_pend;
        sb.push_back(nr);
        m_pend = 1'b0;
      end else begin
        if (m_drop != 16'hffff) m_drop = m_drop + 16'd1;
        m_pend = 1'b1;
      end
    end
    m_sticky = (clr ? 4'b0000 : m_sticky) | rise;
    if (s) begin
      m_prev = r;
      m_sym  = m_sym + 32'd1;
    end
    @(posedge clk); #1;
    report_strobe = 1'b0; clear_sticky = 1'b0; rec_ready = 1'b0;
  endtask

  function automatic logic [3:0] alt_val();
    return (m_prev == 4'b0010) ? 4'b0001 : 4'b0010;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++; if (rec_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", rec_valid); else passed++;
    checks++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
    checks++; if (dropped_count !== 16'd0) $display("FAIL reset_dropped: got %0d expected 0", dropped_count); else passed++;
    checks++; if (sticky_status !== 4'd0) $display("FAIL reset_sticky: got %b expected 0000", sticky_status); else passed++;
  endtask

  task automatic test_basic();
    logic p; rec_t o, e;
    logic [3:0] pat [5];
    pat[0] = 4'b0000; pat[1] = 4'b0010; pat[2] = 4'b0010; pat[3] = 4'b0000; pat[4] = 4'b0010;
    for (int i = 0; i < 5; i++) cycle(1'b1, pat[i], 1'b0, 1'b0, p, o, e);
    checks++; if (fifo_count !== 4'd2) $display("FAIL basic_count: got %0d expected 2", fifo_count); else passed++;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b0000, 1'b0, 1'b1, p, o, e);
      checks++; if (!p || o !== e) $display("FAIL basic_rec%0d: got v=%0b rep=%b ts=%0d id=%0d ovf=%0b expected rep=%b ts=%0d id=%0d ovf=%0b", i, p, o.rep, o.ts, o.id, o.ovf, e.rep, e.ts, e.id, e.ovf); else passed++;
      checks++; if (o.rep !== 4'b0010 || o.ts !== (i == 0 ? 32'd1 : 32'd4) || o.id !== 4'd7 || o.ovf !== 1'b0) $display("FAIL basic_const%0d: got rep=%b ts=%0d id=%0d ovf=%0b", i, o.rep, o.ts, o.id, o.ovf); else passed++;
    end
    checks++; if (fifo_count !== 4'd0) $display("FAIL basic_empty: got %0d expected 0", fifo_count); else passed++;
  endtask

  task automatic test_latency();
    logic p; rec_t o, e;
    cycle(1'b0, 4'b0000, 1'b1, 1'b0, p, o, e);
    cycle(1'b1, 4'b1001, 1'b0, 1'b1, p, o, e);
    checks++; if (p !== 1'b0) $display("FAIL lat_early: got valid %0b expected 0", p); else passed++;
    cycle(1'b0, 4'b1001, 1'b0, 1'b1, p, o, e);
    checks++; if (!p || o !== e || o.rep !== 4'b1001) $display("FAIL lat_rec: got v=%0b rep=%b ts=%0d expected rep=1001 ts=%0d", p, o.rep, o.ts, e.ts); else passed++;
    checks++; if (fifo_count !== 4'd0) $display("FAIL lat_count: got %0d expected 0", fifo_count); else passed++;
    checks++; if (sticky_status !== 4'b1001 || sticky_status !== m_sticky) $display("FAIL lat_sticky: got %b expected 1001", sticky_status); else passed++;
  endtask

  task automatic test_overflow();
    logic p; rec_t o, e;
    logic [31:0] last_ts;
    for (int i = 0; i < 10; i++) cycle(1'b1, alt_val(), 1'b0, 1'b0, p, o, e);
    checks++; if (fifo_count !== 4'd8) $display("FAIL ovf_count: got %0d expected 8", fifo_count); else passed++;
    checks++; if (dropped_count !== 16'd2 || dropped_count !== m_drop) $display("FAIL ovf_dropped: got %0d expected 2", dropped_count); else passed++;
    last_ts = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, m_prev, 1'b0, 1'b1, p, o, e);
      checks++; if (!p || o !== e || o.ovf !== 1'b0 || (i > 0 && o.ts <= last_ts)) $display("FAIL ovf_drain%0d: got v=%0b rep=%b ts=%0d ovf=%0b expected rep=%b ts=%0d ovf=0", i, p, o.rep, o.ts, o.ovf, e.rep, e.ts); else passed++;
      last_ts = o.ts;
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, alt_val(), 1'b0, 1'b0, p, o, e);
      cycle(1'b0, m_prev, 1'b0, 1'b1, p, o, e);
      checks++; if (!p || o !== e || o.ovf !== (i == 0)) $display("FAIL ovf_flag%0d: got v=%0b ts=%0d ovf=%0b expected ts=%0d ovf=%0b", i, p, o.ts, o.ovf, e.ts, i == 0); else passed++;
    end
  endtask

  task automatic test_full_pop();
    logic p; rec_t o, e;
    for (int i = 0; i < 8; i++) cycle(1'b1, alt_val(), 1'b0, 1'b0, p, o, e);
    cycle(1'b1, alt_val(), 1'b0, 1'b1, p, o, e);
    checks++; if (!p || o !== e) $display("FAIL fullpop_head: got v=%0b ts=%0d expected ts=%0d", p, o.ts, e.ts); else passed++;
    checks++; if (fifo_count !== 4'd7) $display("FAIL fullpop_count: got %0d expected 7", fifo_count); else passed++;
    checks++; if (dropped_count !== 16'd3 || dropped_count !== m_drop) $display("FAIL fullpop_dropped: got %0d expected 3", dropped_count); else passed++;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, m_prev, 1'b0, 1'b1, p, o, e);
      checks++; if (!p || o !== e) $display("FAIL fullpop_drain%0d: got v=%0b ts=%0d ovf=%0b expected ts=%0d ovf=%0b", i, p, o.ts, o.ovf, e.ts, e.ovf); else passed++;
    end
  endtask

  task automatic test_sticky();
    logic p; rec_t o, e;
    cycle(1'b1, 4'b0000, 1'b0, 1'b0, p, o, e);
    cycle(1'b1, 4'b0100, 1'b1, 1'b0, p, o, e);
    checks++; if (sticky_status !== 4'b0100 || sticky_status !== m_sticky) $display("FAIL sticky_setwins: got %b expected 0100", sticky_status); else passed++;
    cycle(1'b0, 4'b0000, 1'b1, 1'b0, p, o, e);
    checks++; if (sticky_status !== 4'b0000) $display("FAIL sticky_clear: got %b expected 0000", sticky_status); else passed++;
    cycle(1'b0, 4'b0000, 1'b0, 1'b1, p, o, e);
    checks++; if (!p || o !== e || o.rep !== 4'b0100 || o.ovf !== 1'b1) $display("FAIL sticky_rec: got v=%0b rep=%b ovf=%0b expected rep=0100 ovf=1", p, o.rep, o.ovf); else passed++;
  endtask

  task automatic test_no_strobe();
    logic p; rec_t o, e;
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'(i * 5 + 1), 1'b0, 1'b0, p, o, e);
    checks++; if (rec_valid !== 1'b0 || fifo_count !== 4'd0) $display("FAIL nostrobe_empty: got v=%0b count=%0d expected 0", rec_valid, fifo_count); else passed++;
    cycle(1'b1, 4'b1000, 1'b0, 1'b0, p, o, e);
    cycle(1'b0, 4'b0000, 1'b0, 1'b1, p, o, e);
    checks++; if (!p || o !== e) $display("FAIL nostrobe_ts: got v=%0b ts=%0d expected ts=%0d", p, o.ts, e.ts); else passed++;
  endtask

  task automatic test_reset_mid();
    logic p; rec_t o, e;
    for (int i = 0; i < 3; i++) cycle(1'b1, alt_val(), 1'b0, 1'b0, p, o, e);
    checks++; if (fifo_count !== 4'd3) $display("FAIL rstmid_pre: got %0d expected 3", fifo_count); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rec_valid !== 1'b0 || fifo_count !== 4'd0) $display("FAIL rstmid_flush: got v=%0b count=%0d expected 0", rec_valid, fifo_count); else passed++;
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 4'b0001, 1'b0, 1'b0, p, o, e);
    cycle(1'b0, 4'b0000, 1'b0, 1'b1, p, o, e);
    checks++; if (!p || o !== e || o.ts !== 32'd0 || o.rep !== 4'b0001) $display("FAIL rstmid_ts: got v=%0b rep=%b ts=%0d expected rep=0001 ts=0", p, o.rep, o.ts); else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_latency();
    test_overflow();
    test_full_pop();
    test_sticky();
    test_no_strobe();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
